id_gen: RTL and testbench
=========================

// Module: id_gen
// PURPOSE
//  Token transmitter for the identifier character stream.
//  On a start request it emits one identifier as 8-bit ASCII, one char per accepted beat:
//  LET_N lowercase letters, then DIG_N decimal digits, then one separator char.
//  It drives the char bus of the identifier recogniser, both as a stimulus source and as
//  the producer side of the char link. Letter/digit values are deterministic from a seed.
// PARAMETERS
//  LEN_W     4       width of length fields; max token part length 2**LEN_W-1
//  SEP_CHAR  8'h20   terminator char (non-alphanumeric); resets recogniser
// PORTS
//  clk         in   1      single clock, all logic on posedge
//  rst         in   1      synchronous reset, active-high
//  start       in   1      request a token; sampled only in IDLE
//  let_len     in   LEN_W  letter count; 0 is treated as 1
//  dig_len     in   LEN_W  digit count; 0 is treated as 1
//  seed        in   8      start offset for letter/digit sequences
//  char        out  8      current character (registered)
//  char_valid  out  1      char holds a valid beat
//  char_ready  in   1      sink accepts beat when char_valid&&char_ready
//  busy        out  1      high in any state other than IDLE
//  done        out  1      one-cycle pulse in the cycle after SEP beat accepted
// BEHAVIOUR
//  Reset: state=IDLE; char=8'h00; char_valid=0; busy=0; done=0; counters cleared.
//  Reset mid-token aborts immediately; no separator is emitted.
//  FSM states are IDLE, LET, DIG and SEP.
//   IDLE: start=1 -> capture clamped lengths and start offsets, go to LET.
//         char_valid=1 and char=first letter on the next cycle (1-cycle latency).
//   LET: on each accepted beat, decrement the letter count and advance the letter pointer.
//        Last letter accepted -> DIG; first digit presented in the very next cycle.
//   DIG: same, using the digit pointer. Last digit accepted -> SEP.
//   SEP: char=SEP_CHAR. Accepted -> IDLE; char_valid=0, done=1 for one cycle.
//        A new start is honoured no earlier than the cycle in which done is high.
//  Handshake:
//   - While char_valid && !char_ready, char and state hold stable (no drop, no skip).
//   - char_valid never deasserts mid-token; the token is gap-free when char_ready=1.
//   - start while busy is ignored, not queued; inputs are sampled only at acceptance.
//  Sequence arithmetic:
//   - Letter pointer lp in 0..25, start value s5=seed[4:0], s5>=26 ? s5-26 : s5.
//     char = "a"+lp; lp wraps 25->0.
//   - Digit pointer dp in 0..9, start value s4=seed[3:0], s4>=10 ? s4-10 : s4.
//     char = "0"+dp; dp wraps 9->0.
//   - Counts are down-counters loaded with clamped length. The last beat is count==1.
//  Token length = let_len' + dig_len' + 1 beats (primes = clamped). Max 2*(2**LEN_W-1)+1.
//  char returns to 8'h00 in IDLE.
// STRUCTURE
//  Shared package (id_pkg):
//   - char constants CH_a, CH_0, SEP_CHAR default
//   - state encoding ST_IDLE/ST_LET/ST_DIG/ST_SEP, 2 bits
//   - modulus constants N_LET=26, N_DIG=10
//  Sub-module id_wrap_ctr: modulo-N counter, params N and W.
//   - Inputs: load, load_val, inc. Output: value.
//   - Wrap at N-1 -> 0. Instantiated twice (letters, digits).
//  Top level contains FSM, length down-counters and output register.
// TESTING
//  1) let=2, dig=3, seed=0, ready=1
//     -> chars "a","b","0","1","2",8'h20 on 6 consecutive cycles, then done.
//  2) let=3, dig=3, seed=25
//     -> "z","a","b","9","0","1",SEP (both pointers wrap).
//     seed=8'hFF -> first letter "f" (31-26), first digit "5".
//  3) Backpressure: ready low 3 cycles on the 2nd beat of test 1
//     -> "b" held stable 3 cycles; no beat lost or duplicated.
//  4) let=0, dig=0 -> treated as 1/1: emits "a","0",SEP. start pulsed while busy -> ignored.
//  5) rst asserted during DIG -> next cycle char_valid=0, busy=0, no done, no SEP.
//     New start then works normally.
//  6) Loopback into identifier recogniser, random seeds and lengths:
//     - recogniser out=1 exactly on digit beats
//     - out=0 after SEP
//     - char_valid beats match the expected string from a reference model

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the identifier token generator: character
// constants, moduli of the letter/digit sequences and the FSM encoding.
package id_pkg;

   localparam logic [7:0] CH_a         = 8'h61;
   localparam logic [7:0] CH_0         = 8'h30;
   localparam logic [7:0] SEP_CHAR_DEF = 8'h20;

   localparam int N_LET = 26;
   localparam int N_DIG = 10;
   localparam int LET_W = 5;
   localparam int DIG_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LET  = 2'd1,
      ST_DIG  = 2'd2,
      ST_SEP  = 2'd3
   } state_t;

   // First letter offset: low five seed bits folded into 0..25.
   function automatic logic [LET_W-1:0] let_start(input logic [7:0] seed);
      logic [LET_W-1:0] s5;
      s5 = seed[4:0];
      return (s5 >= 5'd26) ? s5 - 5'd26 : s5;
   endfunction

   // First digit offset: low four seed bits folded into 0..9.
   function automatic logic [DIG_W-1:0] dig_start(input logic [7:0] seed);
      logic [DIG_W-1:0] s4;
      s4 = seed[3:0];
      return (s4 >= 4'd10) ? s4 - 4'd10 : s4;
   endfunction

endpackage

// File: rtl/id_gen_if.sv
// Character link between the token generator (producer) and a sink such
// as the identifier recogniser. A beat transfers when valid and ready are
// both high on a rising clock edge.
interface id_gen_if;

   logic [7:0] char_data;
   logic       char_valid;
   logic       char_ready;

   modport master (
      output char_data,
      output char_valid,
      input  char_ready
   );

   modport slave (
      input  char_data,
      input  char_valid,
      output char_ready
   );

endinterface

// File: rtl/id_wrap_ctr.sv
// Modulo-N counter with synchronous load and increment. Besides the
// current value it exposes the value it will hold after the next edge so
// the owner can register a decoded version of it without extra latency.
module id_wrap_ctr #(
   parameter int N = 10,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_inc,
   output logic [W-1:0] o_value,
   output logic [W-1:0] o_next
);

   logic [W-1:0] r_value;
   logic [W-1:0] w_next;

   // Load has priority over increment; increment wraps N-1 back to zero.
   always_comb begin
      w_next = r_value;
      if (i_load) begin
         w_next = i_load_val;
      end else if (i_inc) begin
         if (r_value == W'(N - 1)) begin
            w_next = '0;
         end else begin
            w_next = r_value + W'(1);
         end
      end
   end

   // Counter register, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_value <= '0;
      end else begin
         r_value <= w_next;
      end
   end

   assign o_value = r_value;
   assign o_next  = w_next;

endmodule

// File: rtl/id_gen.sv
// Identifier token generator: on start it streams LET_N lowercase letters,
// DIG_N decimal digits and one separator over a valid/ready char link.
// Letter and digit values follow wrapping sequences offset by the seed.
module id_gen
   import id_pkg::*;
#(
   parameter int         LEN_W    = 4,
   parameter logic [7:0] SEP_CHAR = SEP_CHAR_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_let_len,
   input  logic [LEN_W-1:0] i_dig_len,
   input  logic [7:0]       i_seed,
   id_gen_if.master         chr_if,
   output logic             o_busy,
   output logic             o_done
);

   localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LEN_W-1:0] r_let_cnt;
   logic [LEN_W-1:0] r_dig_cnt;
   logic [7:0]       r_char;
   logic             r_valid;
   logic             r_done;

   logic             w_accept;
   logic             w_launch;
   logic             w_let_inc;
   logic             w_dig_inc;
   logic [LEN_W-1:0] w_let_len_c;
   logic [LEN_W-1:0] w_dig_len_c;
   logic [LET_W-1:0] w_lp;
   logic [LET_W-1:0] w_lp_nxt;
   logic [DIG_W-1:0] w_dp;
   logic [DIG_W-1:0] w_dp_nxt;
   logic [7:0]       w_char_nxt;

   assign w_accept    = r_valid && chr_if.char_ready;
   assign w_launch    = (r_state == ST_IDLE) && i_start;
   assign w_let_inc   = (r_state == ST_LET) && w_accept;
   assign w_dig_inc   = (r_state == ST_DIG) && w_accept;
   assign w_let_len_c = (i_let_len == '0) ? LEN_ONE : i_let_len;
   assign w_dig_len_c = (i_dig_len == '0) ? LEN_ONE : i_dig_len;

   id_wrap_ctr #(.N(N_LET), .W(LET_W)) u_let_ptr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_launch),
      .i_load_val (let_start(i_seed)),
      .i_inc      (w_let_inc),
      .o_value    (w_lp),
      .o_next     (w_lp_nxt)
   );

   id_wrap_ctr #(.N(N_DIG), .W(DIG_W)) u_dig_ptr (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_launch),
      .i_load_val (dig_start(i_seed)),
      .i_inc      (w_dig_inc),
      .o_value    (w_dp),
      .o_next     (w_dp_nxt)
   );

   // Next-state logic: each phase advances only when its last beat is taken.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (i_start) w_state_nxt = ST_LET;
         ST_LET:  if (w_accept && (r_let_cnt == LEN_ONE)) w_state_nxt = ST_DIG;
         ST_DIG:  if (w_accept && (r_dig_cnt == LEN_ONE)) w_state_nxt = ST_SEP;
         ST_SEP:  if (w_accept) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Character that will be on the link next cycle, derived from the next
   // state and next pointer values so the output can be a plain register.
   always_comb begin
      w_char_nxt = 8'h00;
      case (w_state_nxt)
         ST_LET:  w_char_nxt = CH_a + {{(8-LET_W){1'b0}}, w_lp_nxt};
         ST_DIG:  w_char_nxt = CH_0 + {{(8-DIG_W){1'b0}}, w_dp_nxt};
         ST_SEP:  w_char_nxt = SEP_CHAR;
         default: w_char_nxt = 8'h00;
      endcase
   end

   // State register; a reset mid-token drops straight back to idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Remaining-beat down-counters, loaded with the clamped lengths at start.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_let_cnt <= '0;
         r_dig_cnt <= '0;
      end else if (w_launch) begin
         r_let_cnt <= w_let_len_c;
         r_dig_cnt <= w_dig_len_c;
      end else begin
         if (w_let_inc) r_let_cnt <= r_let_cnt - LEN_ONE;
         if (w_dig_inc) r_dig_cnt <= r_dig_cnt - LEN_ONE;
      end
   end

   // Output register: char/valid hold while stalled, done pulses after SEP.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_char  <= 8'h00;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_char  <= w_char_nxt;
         r_valid <= (w_state_nxt != ST_IDLE);
         r_done  <= (r_state == ST_SEP) && w_accept;
      end
   end

   assign chr_if.char_data  = r_char;
   assign chr_if.char_valid = r_valid;
   assign o_busy            = (r_state != ST_IDLE);
   assign o_done            = r_done;

endmodule

// File: tb/tb_id_gen.sv
// Directed testbench for the identifier token generator. Each scenario
// task drives a token and compares every beat against a small reference
// model of the letter/digit sequences.
module tb_id_gen;

   logic       clk;
   logic       rst;
   logic       iStart;
   logic [3:0] iLetLen;
   logic [3:0] iDigLen;
   logic [7:0] iSeed;
   logic       oBusy;
   logic       oDone;

   int assertCount;
   int failCount;

   id_gen_if chrIf ();

   id_gen #(.LEN_W(4), .SEP_CHAR(8'h20)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_start   (iStart),
      .i_let_len (iLetLen),
      .i_dig_len (iDigLen),
      .i_seed    (iSeed),
      .chr_if    (chrIf.master),
      .o_busy    (oBusy),
      .o_done    (oDone)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: expected character at beat k of a token.
   function automatic logic [7:0] expChar(input int lc, input int dc,
                                          input logic [7:0] sd, input int k);
      int lp;
      int dp;
      lp = int'(sd[4:0]);
      if (lp >= 26) lp = lp - 26;
      dp = int'(sd[3:0]);
      if (dp >= 10) dp = dp - 10;
      if (k < lc) return 8'h61 + 8'((lp + k) % 26);
      else if (k < lc + dc) return 8'h30 + 8'((dp + k - lc) % 10);
      else return 8'h20;
   endfunction

   // Drives one token and checks every beat. mode 0: always ready,
   // mode 1: ready low 3 cycles on the 2nd beat, mode 2: random ready
   // with a recogniser model checked on every accepted beat.
   task automatic runToken(input int l, input int d, input logic [7:0] sd,
                           input int mode, input bit pulseBusy, input string name);
      int  lc, dc, total, k, cyc, stall;
      bit  rdy;
      bit  seenLet;
      bit  recOut;
      logic [7:0] c;
      lc = (l == 0) ? 1 : l;
      dc = (d == 0) ? 1 : d;
      total = lc + dc + 1;
      k = 0; cyc = 0; stall = 0; seenLet = 0; recOut = 0;

      @(negedge clk);
      iStart = 1'b1; iLetLen = 4'(l); iDigLen = 4'(d); iSeed = sd;
      chrIf.char_ready = 1'b1;
      @(negedge clk);
      iStart = 1'b0; iLetLen = 4'hF; iDigLen = 4'hF; iSeed = 8'hA5;

      assertCount++;
      if (oBusy !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL %s busy_after_start: got %b expected 1", name, oBusy);
      end

      while (k < total && cyc < 200) begin
         case (mode)
            0: rdy = 1'b1;
            1: begin
               rdy = !(k == 1 && stall < 3);
               if (!rdy) stall++;
            end
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         chrIf.char_ready = rdy;
         iStart = (pulseBusy && k == 1) ? 1'b1 : 1'b0;

         assertCount++;
         if (chrIf.char_valid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL %s valid_beat%0d: got %b expected 1", name, k, chrIf.char_valid);
         end else begin
            c = expChar(lc, dc, sd, k);
            assertCount++;
            if (chrIf.char_data !== c) begin
               failCount++;
               $display("[TB] FAIL %s char_beat%0d: got %h expected %h", name, k, chrIf.char_data, c);
            end
            if (rdy) begin
               if (mode == 2) begin
                  if (chrIf.char_data == 8'h20) begin
                     recOut = 1'b0; seenLet = 1'b0;
                  end else if (chrIf.char_data >= 8'h30 && chrIf.char_data <= 8'h39) begin
                     recOut = seenLet;
                  end else begin
                     recOut = 1'b0; seenLet = 1'b1;
                  end
                  assertCount++;
                  if (recOut !== (k >= lc && k < lc + dc)) begin
                     failCount++;
                     $display("[TB] FAIL %s recog_beat%0d: got %b expected %b", name, k, recOut, (k >= lc && k < lc + dc));
                  end
               end
               k++;
            end
         end
         cyc++;
         @(negedge clk);
      end
      iStart = 1'b0;
      chrIf.char_ready = 1'b1;

      assertCount++;
      if (k != total) begin
         failCount++;
         $display("[TB] FAIL %s timeout: got %0d beats expected %0d", name, k, total);
      end

      if (mode == 0) begin
         assertCount++;
         if (cyc != total) begin
            failCount++;
            $display("[TB] FAIL %s gap_free: got %0d cycles expected %0d", name, cyc, total);
         end
      end

      if (mode == 1) begin
         assertCount++;
         if (stall != 3) begin
            failCount++;
            $display("[TB] FAIL %s stall_cycles: got %0d expected 3", name, stall);
         end
      end

      assertCount++;
      if ({oDone, chrIf.char_valid, oBusy} !== 3'b100 || chrIf.char_data !== 8'h00) begin
         failCount++;
         $display("[TB] FAIL %s done_cycle: got done/valid/busy %b char %h expected 100 char 00",
                  name, {oDone, chrIf.char_valid, oBusy}, chrIf.char_data);
      end

      if (mode == 2) begin
         assertCount++;
         if (recOut !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL %s recog_after_sep: got %b expected 0", name, recOut);
         end
      end

      @(negedge clk);
      assertCount++;
      if ({oDone, chrIf.char_valid, oBusy} !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL %s idle_after_done: got done/valid/busy %b expected 000",
                  name, {oDone, chrIf.char_valid, oBusy});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      iStart = 1'b0; iLetLen = 4'd0; iDigLen = 4'd0; iSeed = 8'd0;
      chrIf.char_ready = 1'b1;
      repeat (2) @(negedge clk);
      assertCount++;
      if ({chrIf.char_valid, oBusy, oDone} !== 3'b000 || chrIf.char_data !== 8'h00) begin
         failCount++;
         $display("[TB] FAIL reset_state: got valid/busy/done %b char %h expected 000 char 00",
                  {chrIf.char_valid, oBusy, oDone}, chrIf.char_data);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      runToken(2, 3, 8'h00, 0, 1'b0, "basic");
   endtask

   task automatic test_wrap();
      runToken(3, 3, 8'd25, 0, 1'b0, "wrap");
      runToken(1, 1, 8'hFF, 0, 1'b0, "seed_ff");
   endtask

   task automatic test_backpressure();
      runToken(2, 3, 8'h00, 1, 1'b0, "backpressure");
   endtask

   task automatic test_zero_len();
      runToken(0, 0, 8'h00, 0, 1'b1, "zero_len");
   endtask

   task automatic test_reset_mid_token();
      @(negedge clk);
      iStart = 1'b1; iLetLen = 4'd2; iDigLen = 4'd5; iSeed = 8'd3;
      chrIf.char_ready = 1'b1;
      @(negedge clk);
      iStart = 1'b0;
      repeat (2) @(negedge clk);
      assertCount++;
      if (chrIf.char_data !== 8'h33) begin
         failCount++;
         $display("[TB] FAIL rst_mid_in_dig: got %h expected 33", chrIf.char_data);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      assertCount++;
      if ({chrIf.char_valid, oBusy, oDone} !== 3'b000 || chrIf.char_data !== 8'h00) begin
         failCount++;
         $display("[TB] FAIL rst_mid_abort: got valid/busy/done %b char %h expected 000 char 00",
                  {chrIf.char_valid, oBusy, oDone}, chrIf.char_data);
      end
      repeat (3) begin
         @(negedge clk);
         assertCount++;
         if ({chrIf.char_valid, oDone} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL rst_mid_quiet: got valid/done %b expected 00", {chrIf.char_valid, oDone});
         end
      end
      runToken(2, 2, 8'd7, 0, 1'b0, "after_reset");
   endtask

   task automatic test_loopback();
      for (int i = 0; i < 6; i++) begin
         runToken(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  8'($urandom_range(0, 255)), 2, 1'b0, "loopback");
      end
   endtask

   initial begin
      assertCount = 0;
      failCount = 0;
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_reset_mid_token();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
